dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Posted-write buffer between the pipeline MEM stage and the data-memory block.
//  Stores are queued in a small FIFO and drained to data memory in order, so the pipeline does not wait for them.
//  Loads have priority over draining. A load that aliases a queued store waits until the buffer is empty.
//  Data-memory side uses that block's protocol: a 1-cycle memread/memwrite request, then its stall rises and falls.
// PARAMETERS
//  DEPTH  4  store FIFO entries; power of two, >=2
// PORTS
//  clk             in   1   single clock, all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  cpu_addr        in   32  byte address from MEM stage
//  cpu_write_data  in   32  store data
//  cpu_memwrite    in   1   store request; held by pipeline while cpu_stall=1
//  cpu_memread     in   1   load request; held by pipeline while cpu_stall=1
//  cpu_sign_mask   in   4   access size/sign code, passed through unchanged
//  cpu_read_data   out  32  load result, registered
//  cpu_stall       out  1   freeze pipeline (combinational)
//  buf_empty       out  1   FIFO empty and no store in flight
//  mem_addr        out  32  to data memory addr, registered
//  mem_write_data  out  32  to data memory write_data, registered
//  mem_memwrite    out  1   1-cycle write request pulse, registered
//  mem_memread     out  1   1-cycle read request pulse, registered
//  mem_sign_mask   out  4   to data memory sign_mask, registered
//  mem_read_data   in   32  from data memory read_data
//  mem_stall       in   1   from data memory clk_stall
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - FIFO cleared; count=0; FSM to IDLE.
//  - All registered outputs 0; buf_empty=1.
//  - Queued or in-flight stores are discarded.
//  FIFO
//  - Each entry holds {addr, data, sign_mask}; registered count 0..DEPTH.
//  - Pointers wrap modulo DEPTH.
//  - The head entry is dequeued only when its write completes.
//  Store acceptance
//  - Enqueue on the edge where cpu_memwrite=1 and count<DEPTH.
//  - Accepted stores cost zero stall cycles.
//  - If count==DEPTH, cpu_stall=1, even if a dequeue happens on the same edge; accept on the next edge.
//  - Enqueue and dequeue on one edge leave count unchanged.
//  Load hazard
//  - hazard = cpu_addr[31:2] matches addr[31:2] of any valid entry, including the in-flight head.
//  - While cpu_memread=1: cpu_stall = ~load_done.
//  - load_done is a 1-cycle registered flag; the load is consumed on the edge closing that cycle.
//  FSM states: IDLE, WAIT_HI, WAIT_LO
//  - IDLE, load go (cpu_memread & ~load_done & ~hazard): mem_memread<=1, mem_* <= cpu fields; go to WAIT_HI.
//  - IDLE, else if count>0: mem_memwrite<=1, mem_* <= head entry; go to WAIT_HI.
//  - IDLE, otherwise: stay.
//  - WAIT_HI: mem_memread/mem_memwrite <= 0 (request is exactly 1 cycle); go to WAIT_LO when mem_stall==1.
//  - WAIT_LO, when mem_stall==0, read: cpu_read_data <= mem_read_data; load_done <= 1; go to IDLE.
//  - WAIT_LO, when mem_stall==0, write: dequeue head; go to IDLE.
//  - mem_stall is never expected high in IDLE; it is ignored there.
//  Ordering and priority
//  - Writes drain in FIFO order.
//  - A non-hazard load bypasses queued stores but never preempts an in-flight write.
//  - A hazard load waits for buf_empty=1.
//  - cpu_memread=1 and cpu_memwrite=1 together is illegal; the store is taken and the bench asserts it never happens.
//  Latency
//  - Load with an idle memory and empty buffer: cpu_stall high for request cycles C0..C4; cpu_read_data valid and stall low in C5.
//  - Each drained store occupies the memory port 5 cycles.
// TESTING
//  T1 rst_n low during WAIT_LO of a write -> next cycle all outputs 0, buf_empty=1; no further mem_memwrite.
//  T2 load 0x1008, model returns 0xDEADBEEF -> cpu_stall high 5 cycles; cpu_read_data=0xDEADBEEF in C5.
//  T3 stores 0x1000..0x100C back to back -> no stall; 5th store stalls until first write completes; model sees 4 writes in order.
//  T4 store 0x12345678@0x1004, then load 0x1006 -> mem_memread only after buf_empty=1; returns model data.
//  T5 two stores queued at 0x1000/0x1004, load 0x1010 -> load issued after in-flight write, before second write.
//  T6 FIFO full, store held across dequeue edge -> accepted next edge; count returns to DEPTH; no entry lost.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the MEM stage and data memory.
// Stores queue in a FIFO; loads bypass unless they alias a queued store.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic        buf_empty,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]   fa [DEPTH];
  logic [31:0]   fd [DEPTH];
  logic [3:0]    fm [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic rd_op;
  logic load_done;
  logic full;
  logic hazard;
  logic enq;
  logic deq;
  logic load_go;
  logic issue_wr;
  logic rd_fin;

  assign full      = (count == (PW+1)'(DEPTH));
  assign enq       = cpu_memwrite & ~full;
  assign buf_empty = (count == '0);

  assign load_go  = (state == IDLE) & cpu_memread
                  & ~cpu_memwrite & ~load_done & ~hazard;
  assign issue_wr = (state == IDLE) & ~load_go
                  & (count != '0);
  assign deq      = (state == WAIT_LO) & ~mem_stall & ~rd_op;
  assign rd_fin   = (state == WAIT_LO) & ~mem_stall & rd_op;

  // A full FIFO stalls a store; a load stalls until its data is back.
  assign cpu_stall = cpu_memwrite ? full
                                  : (cpu_memread & ~load_done);

  // Word-address match against every occupied entry, head included.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - head)} < count &&
          fa[i][31:2] == cpu_addr[31:2])
        hazard = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state: one request, wait for stall rise, then fall.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_go | issue_wr) state_nx = WAIT_HI;
      WAIT_HI: if (mem_stall)          state_nx = WAIT_LO;
      WAIT_LO: if (!mem_stall)         state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  // Memory-side request registers and load result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
      cpu_read_data  <= '0;
      rd_op          <= 1'b0;
      load_done      <= 1'b0;
    end else begin
      mem_memwrite <= 1'b0;
      mem_memread  <= 1'b0;
      load_done    <= rd_fin;
      if (rd_fin) cpu_read_data <= mem_read_data;
      if (load_go) begin
        mem_memread    <= 1'b1;
        mem_addr       <= cpu_addr;
        mem_write_data <= cpu_write_data;
        mem_sign_mask  <= cpu_sign_mask;
        rd_op          <= 1'b1;
      end else if (issue_wr) begin
        mem_memwrite   <= 1'b1;
        mem_addr       <= fa[head];
        mem_write_data <= fd[head];
        mem_sign_mask  <= fm[head];
        rd_op          <= 1'b0;
      end
    end
  end

  // Store FIFO: head leaves only when its write completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fa[i] <= '0;
        fd[i] <= '0;
        fm[i] <= '0;
      end
    end else begin
      if (enq) begin
        fa[tail] <= cpu_addr;
        fd[tail] <= cpu_write_data;
        fm[tail] <= cpu_sign_mask;
        tail     <= tail + PW'(1);
      end
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer with a stalling data-memory model
// and a word-level reference memory for loads and write order.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_write_data;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic        buf_empty;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_addr(cpu_addr),
    .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite),
    .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask),
    .cpu_read_data(cpu_read_data),
    .cpu_stall(cpu_stall),
    .buf_empty(buf_empty),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data),
    .mem_stall(mem_stall)
  );

  // Data memory: request pulse, stall high two cycles, then data.
  logic [31:0] mem_arr [1024];
  logic [9:0]  ridx = '0;
  int          busy = 0;
  logic [67:0] wlog [$];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rd_wcount = 0;
  logic        rd_empty = 1'b0;

  function automatic logic [31:0] init_word(int i);
    return (i == 2) ? 32'hDEADBEEF : (32'h5A5A_0000 | 32'(i));
  endfunction

  initial for (int i = 0; i < 1024; i++) mem_arr[i] = init_word(i);

  assign mem_stall     = (busy != 0);
  assign mem_read_data = mem_arr[ridx];

  always @(posedge clk) begin
    if (mem_memwrite) begin
      mem_arr[mem_addr[11:2]] <= mem_write_data;
      wlog.push_back({mem_addr, mem_write_data, mem_sign_mask});
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_memread) begin
      rd_cnt    <= rd_cnt + 1;
      rd_wcount <= wlog.size();
      rd_empty  <= buf_empty;
    end
    if (mem_memread || mem_memwrite) begin
      busy <= 2;
      ridx <= mem_addr[11:2];
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  always @(posedge clk)
    if (rst_n)
      assert (!(cpu_memread && cpu_memwrite))
        else $error("illegal simultaneous load and store");

  // Reference: architectural memory in program order.
  logic [31:0] ref_arr [1024];
  logic [67:0] exp_w [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          output int st);
    cpu_addr       = a;
    cpu_write_data = d;
    cpu_sign_mask  = d[7:4];
    cpu_memwrite   = 1'b1;
    st = 0;
    @(negedge clk);
    while (cpu_stall && st < 200) begin
      st++;
      @(negedge clk);
    end
    if (st >= 200) begin
      checks++;
      errors++;
      $display("FAIL store_timeout addr=%h", a);
    end
    @(posedge clk);
    #1;
    cpu_memwrite = 1'b0;
    ref_arr[a[11:2]] = d;
    exp_w.push_back({a, d, d[7:4]});
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] q,
                         output int st);
    cpu_addr      = a;
    cpu_sign_mask = 4'h2;
    cpu_memread   = 1'b1;
    st = 0;
    @(negedge clk);
    while (cpu_stall && st < 200) begin
      st++;
      @(negedge clk);
    end
    if (st >= 200) begin
      checks++;
      errors++;
      $display("FAIL load_timeout addr=%h", a);
    end
    q = cpu_read_data;
    @(posedge clk);
    #1;
    cpu_memread = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while (!buf_empty && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout buf_empty=%b", buf_empty);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    cpu_addr       = '0;
    cpu_write_data = '0;
    cpu_memwrite   = 1'b0;
    cpu_memread    = 1'b0;
    cpu_sign_mask  = '0;
    #2;
    checks++;
    if ({mem_addr, mem_write_data, mem_memwrite, mem_memread,
         mem_sign_mask} !== '0) begin
      errors++;
      $display("FAIL reset_mem_outputs got addr=%h wd=%h we=%b re=%b m=%h want 0",
               mem_addr, mem_write_data, mem_memwrite, mem_memread,
               mem_sign_mask);
    end
    checks++;
    if (cpu_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_read_data got %h want 0", cpu_read_data);
    end
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_buf_empty got %b want 1", buf_empty);
    end
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", cpu_stall);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_latency();
    logic [31:0] q;
    int st;
    int r0;
    wait_empty();
    r0 = rd_cnt;
    do_load(32'h1008, q, st);
    checks++;
    if (st !== 5) begin
      errors++;
      $display("FAIL load_latency stall_cycles got %0d want 5", st);
    end
    checks++;
    if (q !== ref_arr[10'h002]) begin
      errors++;
      $display("FAIL load_latency data got %h want %h", q, ref_arr[10'h002]);
    end
    checks++;
    if (rd_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL load_latency reads got %0d want 1", rd_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    int wb;
    int eb;
    int nz;
    wait_empty();
    wb = wlog.size();
    eb = exp_w.size();
    nz = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h1000 + 32'(4 * i), $urandom, st);
      if (st != 0) nz++;
    end
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL b2b_no_stall stalled_stores got %0d want 0", nz);
    end
    do_store(32'h1010, $urandom, st);
    checks++;
    if (st == 0) begin
      errors++;
      $display("FAIL b2b_fifth_stall got %0d cycles want >0", st);
    end
    checks++;
    if (wlog.size() - wb !== 1) begin
      errors++;
      $display("FAIL b2b_accept_after_first writes_done got %0d want 1",
               wlog.size() - wb);
    end
    wait_empty();
    checks++;
    if (wlog.size() - wb !== exp_w.size() - eb) begin
      errors++;
      $display("FAIL b2b_write_count got %0d want %0d",
               wlog.size() - wb, exp_w.size() - eb);
    end else begin
      for (int i = 0; i < exp_w.size() - eb; i++) begin
        checks++;
        if (wlog[wb+i] !== exp_w[eb+i]) begin
          errors++;
          $display("FAIL b2b_order[%0d] got %h want %h",
                   i, wlog[wb+i], exp_w[eb+i]);
        end
      end
    end
  endtask

  task automatic test_full_hold();
    int st;
    int wb;
    int eb;
    wait_empty();
    wb = wlog.size();
    eb = exp_w.size();
    for (int i = 0; i < 4; i++)
      do_store(32'h1020 + 32'(4 * i), $urandom, st);
    do_store(32'h1030, $urandom, st);
    checks++;
    if (st !== 2) begin
      errors++;
      $display("FAIL full_hold_stall got %0d want 2", st);
    end
    do_store(32'h1034, $urandom, st);
    checks++;
    if (st !== 4) begin
      errors++;
      $display("FAIL full_again_stall got %0d want 4", st);
    end
    wait_empty();
    checks++;
    if (wlog.size() - wb !== 6) begin
      errors++;
      $display("FAIL full_write_count got %0d want 6", wlog.size() - wb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wlog[wb+i] !== exp_w[eb+i]) begin
          errors++;
          $display("FAIL full_order[%0d] got %h want %h",
                   i, wlog[wb+i], exp_w[eb+i]);
        end
      end
    end
  endtask

  task automatic test_hazard();
    logic [31:0] q;
    int st;
    int wb;
    wait_empty();
    wb = wlog.size();
    do_store(32'h1004, 32'h12345678, st);
    do_load(32'h1006, q, st);
    checks++;
    if (rd_empty !== 1'b1) begin
      errors++;
      $display("FAIL hazard_wait_empty buf_empty_at_read got %b want 1",
               rd_empty);
    end
    checks++;
    if (rd_wcount - wb !== 1) begin
      errors++;
      $display("FAIL hazard_order writes_before_read got %0d want 1",
               rd_wcount - wb);
    end
    checks++;
    if (q !== ref_arr[10'h001]) begin
      errors++;
      $display("FAIL hazard_data got %h want %h", q, ref_arr[10'h001]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] q;
    int st;
    int wb;
    wait_empty();
    wb = wlog.size();
    do_store(32'h1000, 32'hA0A0_0001, st);
    do_store(32'h1004, 32'hB0B0_0002, st);
    do_load(32'h1010, q, st);
    checks++;
    if (rd_wcount - wb !== 1) begin
      errors++;
      $display("FAIL bypass_order writes_before_read got %0d want 1",
               rd_wcount - wb);
    end
    checks++;
    if (q !== ref_arr[10'h004]) begin
      errors++;
      $display("FAIL bypass_data got %h want %h", q, ref_arr[10'h004]);
    end
    wait_empty();
    checks++;
    if (wlog.size() - wb !== 2) begin
      errors++;
      $display("FAIL bypass_write_count got %0d want 2", wlog.size() - wb);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] q;
    int st;
    int wb;
    int eb;
    int r;
    wait_empty();
    wb = wlog.size();
    eb = exp_w.size();
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      if (r < 5) begin
        do_store(a, $urandom, st);
      end else if (r < 8) begin
        do_load(a, q, st);
        checks++;
        if (q !== ref_arr[a[11:2]]) begin
          errors++;
          $display("FAIL rand_load addr=%h got %h want %h",
                   a, q, ref_arr[a[11:2]]);
        end
      end else begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    wait_empty();
    checks++;
    if (wlog.size() - wb !== exp_w.size() - eb) begin
      errors++;
      $display("FAIL rand_write_count got %0d want %0d",
               wlog.size() - wb, exp_w.size() - eb);
    end else begin
      for (int i = 0; i < exp_w.size() - eb; i++) begin
        checks++;
        if (wlog[wb+i] !== exp_w[eb+i]) begin
          errors++;
          $display("FAIL rand_order[%0d] got %h want %h",
                   i, wlog[wb+i], exp_w[eb+i]);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    int st;
    int n;
    int wc;
    wait_empty();
    do_store(32'h1020, 32'hCAFE_0001, st);
    do_store(32'h1024, 32'hCAFE_0002, st);
    n = 0;
    @(negedge clk);
    while (!mem_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL midwrite_stall_timeout mem_stall=%b", mem_stall);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_addr, mem_write_data, mem_memwrite, mem_memread,
         mem_sign_mask, cpu_read_data} !== '0) begin
      errors++;
      $display("FAIL midwrite_reset_outputs got addr=%h rd=%h want 0",
               mem_addr, cpu_read_data);
    end
    @(negedge clk);
    checks++;
    if (buf_empty !== 1'b1 || mem_memwrite !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_reset_empty got empty=%b we=%b want 1/0",
               buf_empty, mem_memwrite);
    end
    rst_n = 1'b1;
    wc = wr_cnt;
    repeat (20) tick();
    checks++;
    if (wr_cnt !== wc || buf_empty !== 1'b1) begin
      errors++;
      $display("FAIL midwrite_discard extra_writes got %0d want 0 empty=%b",
               wr_cnt - wc, buf_empty);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_arr[i] = init_word(i);
    test_reset();
    test_load_latency();
    test_back_to_back();
    test_full_hold();
    test_hazard();
    test_bypass();
    test_random();
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
